// File: rtl/rr_arb4.sv
// rr_arb4 -- four-requester round-robin arbiter with grant hold.
//
// One active requester wins per arbitration; the winner is presented as a
// registered 2-bit index (gnt_idx) plus a valid flag (gnt_valid), meant to
// drive the select/enable of a downstream 2-to-4 decoder. A grant is held
// until the owner pulses done or drops its request.
//
// Optional feature: define RR_TIMEOUT_EN to enable the hold counter and the
// forced release after TIMEOUT cycles (timeout pulses for one cycle). With
// the macro undefined the counter is absent, timeout is tied low and a grant
// is held without limit.
//
// Handshake: req[i] is a level request; once granted, the owner keeps
// req[i] high for as long as it wants the resource and either pulses done
// (sampled only while gnt_valid=1) or drops req[i] to release it. Release
// and re-grant never share an edge, so grants are at least 2 cycles apart.

module rr_arb4 #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e     state;
  logic [1:0] ptr;
  logic [1:0] pick_idx;
  logic       release_now;

  // First set request bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Winner selection and the owner-driven release condition.
  always_comb begin
    pick_idx    = rr_pick(req, ptr);
    release_now = done || !req[gnt_idx];
  end

`ifdef RR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Arbitration FSM with hold counter and forced release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= '0;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            cnt       <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 2'd1;
            state     <= IDLE;
          end else if (cnt == CNT_LAST) begin
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 2'd1;
            state     <= IDLE;
            timeout   <= 1'b1;
          end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  // TIMEOUT/CNT_W are accepted but have no effect in this build.
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT > CNT_W);

  // Arbitration FSM; grants are held until done or a request drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 2'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rr_arb4.sv
// tb_rr_arb4 -- directed bench for rr_arb4 (TIMEOUT=4).
// Inputs change #1 after a rising edge; outputs are checked #1 after the
// next rising edge, i.e. one registered step later.

module tb_rr_arb4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  rr_arb4 #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Check the full output triple.
  task automatic check_out(input string tag, input logic v, input logic [1:0] idx, input logic to);
    check({tag, ".valid"}, {1'b0, gnt_valid}, {1'b0, v});
    check({tag, ".idx"}, gnt_idx, idx);
    check({tag, ".timeout"}, {1'b0, timeout}, {1'b0, to});
  endtask

  initial begin
    logic [1:0] seq [5];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;

    // Reset for 5 cycles with no requests.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("reset", 1'b0, 2'd0, 1'b0);
    end
    rst = 1'b0;
    tick();
    check_out("idle_no_req", 1'b0, 2'd0, 1'b0);

    // All requesting, done one cycle after each grant: 0,1,2,3,0.
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check_out("rr_grant", 1'b1, seq[g], 1'b0);
      done = 1'b1;
      tick();
      check_out("rr_release", 1'b0, seq[g], 1'b0);
      done = 1'b0;
    end

    // ptr=1 now: grant 1, then release with req=0011 -> next grant 0.
    tick();
    check_out("grant1", 1'b1, 2'd1, 1'b0);
    done = 1'b1;
    req  = 4'b0011;
    tick();
    check_out("release1", 1'b0, 2'd1, 1'b0);
    done = 1'b0;
    tick();
    check_out("wrap_to0", 1'b1, 2'd0, 1'b0);
    req = 4'b0000;
    tick();
    check_out("drop0", 1'b0, 2'd0, 1'b0);
    tick();
    check_out("stay_idle", 1'b0, 2'd0, 1'b0);

    // Reset mid-grant to index 2, then req=1000 -> grant 3.
    req = 4'b0100;
    tick();
    check_out("grant2", 1'b1, 2'd2, 1'b0);
    rst = 1'b1;
    tick();
    check_out("rst_mid", 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    req = 4'b1000;
    tick();
    check_out("post_rst3", 1'b1, 2'd3, 1'b0);
    req = 4'b0000;
    tick();
    check_out("drop3", 1'b0, 2'd3, 1'b0);

    // ptr=0. Owner 1 drops its request -> next goes to 2 (scan from 2).
    req = 4'b0010;
    tick();
    check_out("grant_o1", 1'b1, 2'd1, 1'b0);
    req = 4'b1101;
    tick();
    check_out("o1_drop", 1'b0, 2'd1, 1'b0);
    tick();
    check_out("after_o1", 1'b1, 2'd2, 1'b0);
    done = 1'b1;
    tick();
    check_out("rel2", 1'b0, 2'd2, 1'b0);
    done = 1'b0;
    tick();
    check_out("grant3", 1'b1, 2'd3, 1'b0);

    // Only requester 2 held with done=0.
    req = 4'b0100;
    tick();
    check_out("rel3_drop", 1'b0, 2'd3, 1'b0);
    tick();
    check_out("hold_grant2", 1'b1, 2'd2, 1'b0);
`ifdef RR_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("hold_to", 1'b1, 2'd2, 1'b0);
    end
    tick();
    check_out("forced_rel", 1'b0, 2'd2, 1'b1);
    tick();
    check_out("regrant2", 1'b1, 2'd2, 1'b0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check_out("hold_nolimit", 1'b1, 2'd2, 1'b0);
    end
`endif
    done = 1'b1;
    tick();
    check_out("final_rel", 1'b0, 2'd2, 1'b0);
    done = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_arb4.md
# rr_arb4

Four-requester round-robin arbiter with grant hold, sitting directly upstream of the 2-to-4 decoder. It chooses one active requester per arbitration and presents the winner as a 2-bit binary index plus a valid flag. The index and valid drive the decoder's select and enable inputs, so the decoder produces the one-hot grant lines. Each grant is held until the owner releases it, which makes the block the sequential front end of a shared-resource select path.

## Interface
- TIMEOUT, 15: maximum cycles a grant may be held before a forced release. Legal range is 2 to 2^CNT_W − 1.
- CNT_W, 4: width of the hold counter.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  [3:0]  request lines; bit i belongs to requester i.
- done  input  1  the current owner releases the grant; sampled only while gnt_valid=1.
- gnt_idx  output  [1:0]  index of the granted requester; connects to the decoder select.
- gnt_valid  output  1  a grant is active; connects to the decoder enable.
- timeout  output  1  one-cycle pulse marking a forced release.

## Operation
- There are two states, IDLE and GRANT. Internal state is a 2-bit priority pointer `ptr`, the hold counter `cnt`, and `state`.
- IDLE with req≠0:
  - Select the first set bit scanning ptr, ptr+1, ptr+2, ptr+3, with indices wrapping mod 4.
  - Register that index into gnt_idx, set gnt_valid=1, set cnt=0, and go to GRANT.
- IDLE with req=0: stay in IDLE; gnt_valid stays 0.
- GRANT releases the grant when either of these holds:
  - done=1, or
  - req[gnt_idx]=0 (the owner dropped its request).
- On release, in a single edge:
  - gnt_valid←0
  - ptr←gnt_idx+1 (wraps 3→0)
  - state←IDLE
- Otherwise, GRANT increments cnt each cycle. The increment saturates and never wraps.
- Forced release (only when RR_TIMEOUT_EN is defined; see Configuration):
  - Condition: in GRANT, cnt==TIMEOUT−1, and no release condition holds.
  - Action: perform the release above and also set timeout=1 for exactly one cycle.
- gnt_idx holds its last value while gnt_valid=0. The decoder ignores it because its enable is low.
- Simultaneous release and new requests in the same cycle: the release wins. New requests are arbitrated on the next IDLE cycle.
- A requester that re-asserts immediately after its own release gets the lowest priority, because ptr has already advanced past it.

## Timing
- Reset values, applied on the first clock edge with rst=1:
  - gnt_valid=0, gnt_idx=2'b00, timeout=0
  - ptr=0, cnt=0, state=IDLE
- Reset overrides everything, including mid-grant: gnt_valid falls on that same edge.
- Grant latency: a req sampled at edge k while in IDLE gives gnt_valid=1 and a valid gnt_idx after edge k (1 cycle).
- Release latency: done or a req drop sampled at edge k gives gnt_valid=0 after edge k.
- There is always at least one cycle with gnt_valid=0 between consecutive grants. Back-to-back grants are 2 cycles apart at best.
- With a timeout and TIMEOUT=N, gnt_valid is high for exactly N cycles. timeout is high in the first cycle that gnt_valid is low.
- All outputs are registered; there is no combinational path from req or done to any output.

## Configuration
- RR_TIMEOUT_EN:
  - Defined: the hold counter and forced release are active, and timeout pulses as described above.
  - Undefined: the counter logic is removed, timeout is tied to 0, and a grant is held until done or a req drop, with no limit.
  - TIMEOUT and CNT_W are still accepted as parameters but are unused.

## Test plan
- Reset with req=4'b0000 for 5 cycles → gnt_valid=0, gnt_idx=0, timeout=0 throughout.
- req=4'b1111 held, done pulsed 1 cycle after each grant → gnt_idx sequence is 0,1,2,3,0, with one idle cycle between grants.
- After granting index 1 (so ptr=2), req=4'b0011 → next grant is 0, skipping over empty slots 2 and 3.
- RR_TIMEOUT_EN defined, TIMEOUT=4, req=4'b0100 held with done=0:
  - gnt_valid is high for 4 cycles, then low with timeout=1 for 1 cycle.
  - gnt_idx=2 is re-granted on the following edge.
- rst asserted during a grant to index 2 → after that edge gnt_valid=0 and ptr=0. Then req=4'b1000 → gnt_idx=3 one cycle later.
- Owner 1 deasserts req[1] while granted with done=0 → gnt_valid falls after that edge and the next grant goes to the lowest-numbered active requester at or after index 2.
